// File: rtl/reg_err_log_reader_if.sv
// rtl/reg_err_log_reader_if.sv - log stream and firmware pop bus for reg_err_log_reader
interface reg_err_log_reader_if #(
  parameter int REG_ADDR_WIDTH = 8,
  parameter int REG_DATA_WIDTH = 32
);
  logic                      log_valid;
  logic [REG_ADDR_WIDTH-1:0] log_addr;
  logic [REG_DATA_WIDTH-1:0] log_data;
  logic [2:0]                log_access_type;
  logic                      rd_req;
  logic                      rd_ack;
  logic [REG_ADDR_WIDTH-1:0] rd_addr;
  logic [REG_DATA_WIDTH-1:0] rd_data;
  logic [2:0]                rd_type;
  logic                      rd_empty;

  // Detector plus firmware side: drives log beats and pop requests
  modport master (
    output log_valid, log_addr, log_data, log_access_type, rd_req,
    input  rd_ack, rd_addr, rd_data, rd_type, rd_empty
  );

  // Log reader side
  modport slave (
    input  log_valid, log_addr, log_data, log_access_type, rd_req,
    output rd_ack, rd_addr, rd_data, rd_type, rd_empty
  );
endinterface

// File: rtl/reg_err_log_reader.sv
// rtl/reg_err_log_reader.sv - register error log FIFO, alert latch and coalesced irq (option: REG_ERR_LOG_FILTER_EN)
module reg_err_log_reader #(
  parameter int REG_ADDR_WIDTH = 8,
  parameter int REG_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int IRQ_THRESH     = 4,
  parameter int IRQ_TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  reg_err_log_reader_if.slave          bus_if,
  input  logic                         alert_line_i,
  input  logic                         alert_ack_i,
  input  logic                         irq_clr_i,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
  output logic [15:0]                  overflow_cnt_o,
  output logic [15:0]                  crit_cnt_o,
  output logic                         alert_latched_o,
  output logic                         irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = REG_ADDR_WIDTH + REG_DATA_WIDTH + 3;
  localparam int TW = $clog2(IRQ_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, ASSERT} irq_state_e;

  logic [EW-1:0]             mem_q [FIFO_DEPTH];
  logic [AW:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]               count;
  logic                      empty, full, push_en, pop_en, accept, drop, is_crit;
  logic [EW-1:0]             head;
  logic                      rd_ack_q, rd_ack_d, rd_empty_q, rd_empty_d;
  logic [EW-1:0]             rd_entry_q, rd_entry_d;
  logic [15:0]               overflow_q, overflow_d, crit_q, crit_d;
  logic                      alert_q, alert_d, alert_seen_q, alert_rise;
  irq_state_e                state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;

`ifdef REG_ERR_LOG_FILTER_EN
  // "none" beats carry no error information and never reach the FIFO
  assign push_en = bus_if.log_valid && (bus_if.log_access_type != 3'd0);
`else
  assign push_en = bus_if.log_valid;
`endif

  // Wrap bit distinguishes full from empty when the index bits match
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_en  = bus_if.rd_req && !empty;
  assign accept  = push_en && (!full || pop_en);
  assign drop    = push_en && !accept;
  assign is_crit = (bus_if.log_access_type == 3'd3) || (bus_if.log_access_type == 3'd4) ||
                   (bus_if.log_access_type == 3'd6);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign alert_rise = alert_q && !alert_seen_q;

  // FIFO pointers, pop response, saturating counters and alert latch next state
  always_comb begin
    wr_ptr_d   = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_ack_d   = bus_if.rd_req;
    rd_empty_d = bus_if.rd_req && empty;
    rd_entry_d = pop_en ? head : '0;
    overflow_d = overflow_q;
    crit_d     = crit_q;
    alert_d    = alert_q;
    if (drop && overflow_q != 16'hFFFF) overflow_d = overflow_q + 16'd1;
    if (accept && is_crit && crit_q != 16'hFFFF) crit_d = crit_q + 16'd1;
    if (alert_line_i) alert_d = 1'b1;
    else if (alert_ack_i) alert_d = 1'b0;
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= {bus_if.log_access_type, bus_if.log_data, bus_if.log_addr};
  end

  // Datapath and FSM state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_ack_q     <= 1'b0;
      rd_empty_q   <= 1'b0;
      rd_entry_q   <= '0;
      overflow_q   <= '0;
      crit_q       <= '0;
      alert_q      <= 1'b0;
      alert_seen_q <= 1'b0;
      state_q      <= IDLE;
      timer_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_ack_q     <= rd_ack_d;
      rd_empty_q   <= rd_empty_d;
      rd_entry_q   <= rd_entry_d;
      overflow_q   <= overflow_d;
      crit_q       <= crit_d;
      alert_q      <= alert_d;
      alert_seen_q <= alert_q;
      state_q      <= state_d;
      timer_q      <= timer_d;
    end
  end

  // IRQ coalescing: wait in ACCUM for threshold, age timeout or a new alert
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (alert_rise) state_d = ASSERT;
        else if (count != '0) state_d = ACCUM;
      end
      ACCUM: begin
        timer_d = timer_q + 1'b1;
        if (alert_rise) begin
          state_d = ASSERT;
          timer_d = '0;
        end else if (count == '0) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (count >= (AW+1)'(IRQ_THRESH) || timer_q == TW'(IRQ_TIMEOUT - 1)) begin
          state_d = ASSERT;
          timer_d = '0;
        end
      end
      ASSERT: begin
        if (irq_clr_i) begin
          timer_d = '0;
          state_d = (count != '0) ? ACCUM : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign bus_if.rd_ack   = rd_ack_q;
  assign bus_if.rd_empty = rd_empty_q;
  assign bus_if.rd_addr  = rd_entry_q[REG_ADDR_WIDTH-1:0];
  assign bus_if.rd_data  = rd_entry_q[REG_ADDR_WIDTH +: REG_DATA_WIDTH];
  assign bus_if.rd_type  = rd_entry_q[EW-1 -: 3];
  assign fifo_count_o    = count;
  assign overflow_cnt_o  = overflow_q;
  assign crit_cnt_o      = crit_q;
  assign alert_latched_o = alert_q;
  assign irq_o           = (state_q == ASSERT);
endmodule
